// File: rtl/spart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_pkg: shared types for the SPART receive path.                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package spart_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_WAIT_HI = 3'd5
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/spart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_sync_fifo: show-ahead FIFO with push/pop/full/empty/count.           |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module spart_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              w_do_push, w_do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | spart_rx_fifo: oversampled serial receiver feeding a show-ahead RX FIFO.   |
// | Option macro SPART_PARITY_EN adds an even-parity bit and parity_err.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OVS    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         baud_tick,
  input  logic                         rxd,
  input  logic                         rd_en,
  input  logic                         clr_err,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         rda,
  output logic [$clog2(DEPTH+1)-1:0]   rx_count,
  output logic                         framing_err,
  output logic                         overrun_err
`ifdef SPART_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);

  rx_state_e               state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d;
  logic                    framing_q, overrun_q;
  logic                    w_rxd_s, w_push, w_frame_set, w_full, w_empty;
  logic                    w_half, w_full_bit;
`ifdef SPART_PARITY_EN
  logic                    par_bad_q, par_bad_d, parity_q, w_par_set;
`endif

  assign w_rxd_s    = sync_q[SYNC_STAGES-1];
  assign w_half     = baud_tick && (cnt_q == CNT_W'(OVS/2 - 1));
  assign w_full_bit = baud_tick && (cnt_q == CNT_W'(OVS - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    w_push      = 1'b0;
    w_frame_set = 1'b0;
`ifdef SPART_PARITY_EN
    par_bad_d   = par_bad_q;
    w_par_set   = 1'b0;
`endif
    if (baud_tick && state_q != ST_IDLE && state_q != ST_WAIT_HI)
      cnt_d = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !w_rxd_s) begin
          state_d = ST_START;
          cnt_d   = '0;
`ifdef SPART_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (w_half) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = w_rxd_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_full_bit) begin
          cnt_d   = '0;
          shreg_d = {w_rxd_s, shreg_q[DATA_W-1:1]};
          if (bit_q == BIT_W'(DATA_W - 1)) begin
`ifdef SPART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef SPART_PARITY_EN
      ST_PARITY: begin
        if (w_full_bit) begin
          cnt_d   = '0;
          state_d = ST_STOP;
          if (^shreg_q ^ w_rxd_s) begin
            w_par_set = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (w_full_bit) begin
          cnt_d = '0;
          if (w_rxd_s) begin
            state_d = ST_IDLE;
`ifdef SPART_PARITY_EN
            w_push  = ~par_bad_q;
`else
            w_push  = 1'b1;
`endif
          end else begin
            w_frame_set = 1'b1;
            state_d     = ST_WAIT_HI;
          end
        end
      end
      ST_WAIT_HI: begin
        // A held break must not look like a fresh start bit.
        if (w_rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SPART_PARITY_EN
      par_bad_q <= 1'b0;
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rxd};
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      framing_q <= (framing_q & ~clr_err) | w_frame_set;
      overrun_q <= (overrun_q & ~clr_err) | (w_push & w_full & ~rd_en);
`ifdef SPART_PARITY_EN
      par_bad_q <= par_bad_d;
      parity_q  <= (parity_q & ~clr_err) | w_par_set;
`endif
    end
  end

  spart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (rd_en),
    .wdata_i (shreg_q),
    .rdata_o (rd_data),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (rx_count)
  );

  assign rda         = ~w_empty;
  assign framing_err = framing_q;
  assign overrun_err = overrun_q;
`ifdef SPART_PARITY_EN
  assign parity_err  = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_spart_rx_fifo: directed self-checking bench for spart_rx_fifo (8N1).    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_spart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst, rxd, rd_en, clr_err;
  logic        baud_tick;
  logic [7:0]  rd_data;
  logic        rda, framing_err, overrun_err;
  logic [2:0]  rx_count;
  logic [31:0] cyc = '0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          rise_at;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // One baud tick every other clock: a bit period is 32 clocks.
  assign baud_tick = cyc[0];

  spart_rx_fifo #(.DATA_W(8), .DEPTH(4), .OVS(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .baud_tick   (baud_tick),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rda         (rda),
    .rx_count    (rx_count),
    .framing_err (framing_err),
    .overrun_err (overrun_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame starts with rxd falling just before a no-tick edge, so the stop
  // sample lands at negedge index 307 and rda rises at index 308.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at);
    logic [9:0] bits;
    logic       prev;
    bits = {stop, d, 1'b0};
    @(negedge clk);
    if (cyc[0]) @(negedge clk);
    rise_at = -1;
    prev    = rda;
    for (int m = 0; m < 320; m++) begin
      if (m > 0) @(negedge clk);
      if (!prev && rda && rise_at < 0) rise_at = m;
      prev  = rda;
      rxd   = bits[m/32];
      rd_en = (m == pop_at);
    end
    @(negedge clk);
    rd_en = 1'b0;
    rxd   = stop;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rda", 32'(rda), 0);
    chk("rst_count", 32'(rx_count), 0);
    chk("rst_data", 32'(rd_data), 0);
    chk("rst_ferr", 32'(framing_err), 0);
    chk("rst_oerr", 32'(overrun_err), 0);

    // single byte, latency of rda after the stop sample
    send_frame(8'hA5, 1'b1, -1);
    chk("t1_rise", 32'(rise_at), 308);
    chk("t1_rda", 32'(rda), 1);
    chk("t1_data", 32'(rd_data), 32'hA5);
    chk("t1_count", 32'(rx_count), 1);
    pop_chk("t1_pop", 8'hA5);
    @(negedge clk);
    chk("t1_empty", 32'(rx_count), 0);

    // short low pulse rejected in START
    @(negedge clk);
    if (cyc[0]) @(negedge clk);
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (60) @(negedge clk);
    chk("t2_rda", 32'(rda), 0);
    chk("t2_ferr", 32'(framing_err), 0);
    chk("t2_oerr", 32'(overrun_err), 0);

    // overrun
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, -1);
    chk("t3_count4", 32'(rx_count), 4);
    chk("t3_oerr_pre", 32'(overrun_err), 0);
    send_frame(8'h05, 1'b1, -1);
    chk("t3_count", 32'(rx_count), 4);
    chk("t3_oerr", 32'(overrun_err), 1);
    for (int b = 1; b <= 4; b++) pop_chk("t3_pop", 8'(b));
    @(negedge clk);
    chk("t3_empty", 32'(rx_count), 0);
    chk("t3_rda", 32'(rda), 0);
    pop_chk("t3_pop_empty", 8'h00);
    @(negedge clk);
    chk("t3_count_after_empty_pop", 32'(rx_count), 0);
    pulse_clr();
    chk("t3_oerr_clr", 32'(overrun_err), 0);

    // framing error and held break
    send_frame(8'h3C, 1'b0, -1);
    chk("t4_ferr", 32'(framing_err), 1);
    chk("t4_rda", 32'(rda), 0);
    repeat (960) @(negedge clk);
    chk("t4_break_count", 32'(rx_count), 0);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("t4_ferr_hold", 32'(framing_err), 1);
    pulse_clr();
    chk("t4_ferr_clr", 32'(framing_err), 0);
    send_frame(8'h3C, 1'b1, -1);
    chk("t4_count", 32'(rx_count), 1);
    chk("t4_ferr_after", 32'(framing_err), 0);
    pop_chk("t4_data", 8'h3C);

    // push and pop on the same cycle while full
    for (int b = 0; b < 4; b++) send_frame(8'h10 + 8'(b), 1'b1, -1);
    chk("t5_full", 32'(rx_count), 4);
    send_frame(8'h77, 1'b1, 307);
    chk("t5_oerr", 32'(overrun_err), 0);
    chk("t5_count", 32'(rx_count), 4);
    pop_chk("t5_pop0", 8'h11);
    pop_chk("t5_pop1", 8'h12);
    pop_chk("t5_pop2", 8'h13);
    pop_chk("t5_tail", 8'h77);

    // reset mid-frame
    send_frame(8'h55, 1'b1, -1);
    chk("t6_pre_count", 32'(rx_count), 1);
    fork
      send_frame(8'hFF, 1'b1, -1);
      begin
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    chk("t6_rda", 32'(rda), 0);
    chk("t6_count", 32'(rx_count), 0);
    chk("t6_data", 32'(rd_data), 0);
    send_frame(8'h12, 1'b1, -1);
    chk("t6_count_after", 32'(rx_count), 1);
    chk("t6_data_after", 32'(rd_data), 32'h12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
